// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared definitions for the forwarding / load-use hazard controller:
// writeback-source codes, forward-word constants and the pipeline slot record.
package hazard_fwd_ctrl_pkg;

    // Writeback source selects (idWbSel encoding)
    localparam logic [1:0] WB_ADDPC = 2'b00;
    localparam logic [1:0] WB_MEM   = 2'b01;
    localparam logic [1:0] WB_ALU   = 2'b10;
    localparam logic [1:0] WB_IMM8  = 2'b11;

    // Forward words: bit3 enable, bit2 0=EX/MEM latch 1=MEM/WB latch, bits1:0 source
    localparam logic [3:0] FW_NONE      = 4'b0000;
    localparam logic [3:0] FW_X2X_ADDPC = 4'b1000;
    localparam logic [3:0] FW_X2X_ALU   = 4'b1010;
    localparam logic [3:0] FW_X2X_IMM8  = 4'b1011;
    localparam logic [3:0] FW_M2X_ADDPC = 4'b1100;
    localparam logic [3:0] FW_M2X_MEM   = 4'b1101;
    localparam logic [3:0] FW_M2X_ALU   = 4'b1110;
    localparam logic [3:0] FW_M2X_IMM8  = 4'b1111;

    localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

    // One in-flight producer: valid only when it writes the register file
    typedef struct packed {
        logic       valid;
        logic [2:0] dest;
        logic [1:0] wb_sel;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '{valid: 1'b0, dest: 3'd0, wb_sel: 2'd0};

    // EX/MEM-latch forward word for a producer one ahead (never called for WB_MEM)
    function automatic logic [3:0] x2x_code(input logic [1:0] wb_sel);
        return {2'b10, wb_sel};
    endfunction

    // MEM/WB-latch forward word for a producer two ahead
    function automatic logic [3:0] m2x_code(input logic [1:0] wb_sel);
        return {2'b11, wb_sel};
    endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_sel.sv
// Per-operand forward selection: compares one decode source register against
// the EX and MEM producer slots and returns the forward word plus a load-use hit.
import hazard_fwd_ctrl_pkg::*;

module fwd_sel (
    input  logic       id_valid_i,
    input  logic       uses_i,
    input  logic [2:0] rs_i,
    input  slot_t      ex_slot_i,
    input  slot_t      mem_slot_i,
    output logic [3:0] fw_word_o,
    output logic       load_hit_o
);

    logic reads;
    logic ex_match;
    logic mem_match;

    assign reads     = id_valid_i & uses_i;
    assign ex_match  = reads & ex_slot_i.valid  & (ex_slot_i.dest  == rs_i);
    assign mem_match = reads & mem_slot_i.valid & (mem_slot_i.dest == rs_i);

    // A load one ahead cannot be forwarded yet; it is a load-use hit instead
    assign load_hit_o = ex_match & (ex_slot_i.wb_sel == WB_MEM);

    // Younger producer (EX slot) wins over the older one (MEM slot)
    always_comb begin
        fw_word_o = FW_NONE;
        if (ex_match && (ex_slot_i.wb_sel != WB_MEM)) begin
            fw_word_o = x2x_code(ex_slot_i.wb_sel);
        end else if (mem_match) begin
            fw_word_o = m2x_code(mem_slot_i.wb_sel);
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Forwarding and load-use hazard controller beside the ID/EX register.
// Tracks the two producers ahead of decode, registers the forward words for the
// instruction entering EX, and raises a one-cycle load-use stall.
import hazard_fwd_ctrl_pkg::*;

module hazard_fwd_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        idValid,
    input  logic [2:0]  idRsA,
    input  logic [2:0]  idRsB,
    input  logic        idUsesA,
    input  logic        idUsesB,
    input  logic        idRegWrite,
    input  logic [2:0]  idDest,
    input  logic [1:0]  idWbSel,
    input  logic        memStall,
    input  logic        flush,
    output logic [3:0]  fwCntrlA,
    output logic [3:0]  fwCntrlB,
    output logic        stall,
    output logic [15:0] stallCount
);

    slot_t       ex_slot_q, ex_slot_d;
    slot_t       mem_slot_q, mem_slot_d;
    logic [3:0]  fw_a_q, fw_a_d;
    logic [3:0]  fw_b_q, fw_b_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic [3:0]  fw_a_w, fw_b_w;
    logic        hit_a, hit_b;
    logic        hazard;
    logic        squash;

    fwd_sel u_sel_a (
        .id_valid_i (idValid),
        .uses_i     (idUsesA),
        .rs_i       (idRsA),
        .ex_slot_i  (ex_slot_q),
        .mem_slot_i (mem_slot_q),
        .fw_word_o  (fw_a_w),
        .load_hit_o (hit_a)
    );

    fwd_sel u_sel_b (
        .id_valid_i (idValid),
        .uses_i     (idUsesB),
        .rs_i       (idRsB),
        .ex_slot_i  (ex_slot_q),
        .mem_slot_i (mem_slot_q),
        .fw_word_o  (fw_b_w),
        .load_hit_o (hit_b)
    );

    // Flush beats the hazard; a frozen pipeline defers it until memStall drops
    assign hazard = hit_a | hit_b;
    assign stall  = hazard & ~flush & ~memStall;
    assign squash = stall | flush;

    // Next-state for slots, forward words and the saturating stall counter
    always_comb begin
        ex_slot_d   = ex_slot_q;
        mem_slot_d  = mem_slot_q;
        fw_a_d      = fw_a_q;
        fw_b_d      = fw_b_q;
        stall_cnt_d = stall_cnt_q;
        if (!memStall) begin
            mem_slot_d = ex_slot_q;
            if (squash || !idValid) begin
                ex_slot_d = SLOT_EMPTY;
            end else begin
                ex_slot_d = '{valid: idRegWrite, dest: idDest, wb_sel: idWbSel};
            end
            fw_a_d = squash ? FW_NONE : fw_a_w;
            fw_b_d = squash ? FW_NONE : fw_b_w;
            if (stall && (stall_cnt_q != STALL_CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end
    end

    // State registers; reset empties both slots so no stale producer survives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_slot_q   <= SLOT_EMPTY;
            mem_slot_q  <= SLOT_EMPTY;
            fw_a_q      <= FW_NONE;
            fw_b_q      <= FW_NONE;
            stall_cnt_q <= 16'd0;
        end else begin
            ex_slot_q   <= ex_slot_d;
            mem_slot_q  <= mem_slot_d;
            fw_a_q      <= fw_a_d;
            fw_b_q      <= fw_b_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwCntrlA   = fw_a_q;
    assign fwCntrlB   = fw_b_q;
    assign stallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: directed pipeline scenarios with fixed expected
// words, then randomized traffic against an instruction-history model.
module tb_hazard_fwd_ctrl;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [2:0]  rs_a, rs_b;
    logic        uses_a, uses_b;
    logic        reg_write;
    logic [2:0]  dest;
    logic [1:0]  wb_sel;
    logic        mem_stall;
    logic        flush;
    logic [3:0]  fw_a, fw_b;
    logic        stall;
    logic [15:0] stall_count;

    int n_vec;
    int n_err;

    hazard_fwd_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .idValid    (id_valid),
        .idRsA      (rs_a),
        .idRsB      (rs_b),
        .idUsesA    (uses_a),
        .idUsesB    (uses_b),
        .idRegWrite (reg_write),
        .idDest     (dest),
        .idWbSel    (wb_sel),
        .memStall   (mem_stall),
        .flush      (flush),
        .fwCntrlA   (fw_a),
        .fwCntrlB   (fw_b),
        .stall      (stall),
        .stallCount (stall_count)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // History of instructions that entered EX: [0] is one ahead of decode, [1] two ahead.
    typedef struct packed {
        logic       v;
        logic [2:0] d;
        logic [1:0] wb;
    } prod_t;

    prod_t       prod_q[$];
    logic [3:0]  exp_fa, exp_fb;
    int          exp_cnt;
    logic        stall_seen;

    function automatic void model_reset();
        prod_q.delete();
        prod_q.push_back('0);
        prod_q.push_back('0);
        exp_fa  = 4'd0;
        exp_fb  = 4'd0;
        exp_cnt = 0;
    endfunction

    // Nearest matching producer wins; a load one ahead cannot be forwarded.
    // Word = 8 (enable) + 4*distance_beyond_EX + writeback source.
    function automatic logic [3:0] model_fw(input logic [2:0] rs, input logic uses);
        if (!id_valid || !uses) return 4'd0;
        for (int age = 0; age < 2; age++) begin
            if (prod_q[age].v && prod_q[age].d == rs && !(age == 0 && prod_q[age].wb == 2'b01))
                return 4'(8 + 4 * age + int'(prod_q[age].wb));
        end
        return 4'd0;
    endfunction

    function automatic logic model_hazard();
        logic hit;
        hit = (uses_a && prod_q[0].d == rs_a) || (uses_b && prod_q[0].d == rs_b);
        return id_valid && prod_q[0].v && prod_q[0].wb == 2'b01 && hit;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [2:0] ra, input logic ua,
                         input logic [2:0] rb, input logic ub, input logic rw,
                         input logic [2:0] d, input logic [1:0] wb,
                         input logic ms, input logic fl);
        id_valid = v; rs_a = ra; uses_a = ua; rs_b = rb; uses_b = ub;
        reg_write = rw; dest = d; wb_sel = wb; mem_stall = ms; flush = fl;
    endtask

    task automatic nop();
        drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
    endtask

    // One pipeline cycle: check combinational stall mid-cycle, then registered outputs.
    task automatic step();
        logic  exp_stall, sq;
        logic  [3:0] nfa, nfb;
        prod_t np;
        @(negedge clk);
        exp_stall  = model_hazard() && !flush && !mem_stall;
        stall_seen = stall;
        check("stall", {15'd0, stall}, {15'd0, exp_stall});
        nfa = model_fw(rs_a, uses_a);
        nfb = model_fw(rs_b, uses_b);
        @(posedge clk);
        if (!mem_stall) begin
            sq     = exp_stall || flush;
            exp_fa = sq ? 4'd0 : nfa;
            exp_fb = sq ? 4'd0 : nfb;
            np.v   = id_valid && reg_write && !sq;
            np.d   = dest;
            np.wb  = wb_sel;
            prod_q.push_front(np);
            prod_q.pop_back();
            if (exp_stall && exp_cnt < 65535) exp_cnt++;
        end
        #1;
        check("fwA", {12'd0, fw_a}, {12'd0, exp_fa});
        check("fwB", {12'd0, fw_b}, {12'd0, exp_fb});
        check("stallCount", stall_count, 16'(exp_cnt));
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear at once.
    task automatic pulse_rst();
        #2 rst = 1'b1;
        #1;
        check("rst_stall", {15'd0, stall}, 16'd0);
        check("rst_fwA", {12'd0, fw_a}, 16'd0);
        check("rst_fwB", {12'd0, fw_b}, 16'd0);
        check("rst_cnt", stall_count, 16'd0);
        model_reset();
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        nop();
        rst = 1'b1;
        #12;
        check("reset_fwA", {12'd0, fw_a}, 16'd0);
        check("reset_fwB", {12'd0, fw_b}, 16'd0);
        check("reset_stall", {15'd0, stall}, 16'd0);
        check("reset_cnt", stall_count, 16'd0);
        rst = 1'b0;

        // ADD R1 ; ADD R2,R1,R3 -> X2X ALU on A
        drive(1, 3'd0, 1, 3'd0, 1, 1, 3'd1, 2'b10, 0, 0); step();
        drive(1, 3'd1, 1, 3'd3, 1, 1, 3'd2, 2'b10, 0, 0); step();
        check("x2x_alu_A", {12'd0, fw_a}, 16'b1010);
        check("x2x_alu_stall", {15'd0, stall_seen}, 16'd0);

        // ADD R1 ; NOP ; SUB R4,R3,R1 -> M2X ALU on B
        drive(1, 3'd0, 0, 3'd0, 0, 1, 3'd1, 2'b10, 0, 0); step();
        nop(); step();
        drive(1, 3'd3, 1, 3'd1, 1, 1, 3'd4, 2'b10, 0, 0); step();
        check("m2x_alu_B", {12'd0, fw_b}, 16'b1110);

        // R1 written by both slots -> younger wins
        drive(1, 3'd0, 0, 3'd0, 0, 1, 3'd1, 2'b11, 0, 0); step();
        drive(1, 3'd0, 0, 3'd0, 0, 1, 3'd1, 2'b10, 0, 0); step();
        drive(1, 3'd1, 1, 3'd0, 0, 1, 3'd2, 2'b10, 0, 0); step();
        check("younger_wins", {12'd0, fw_a}, 16'b1010);

        // LD R5 ; ADD R6,R5,R5 -> one bubble, then M2X mem on both
        drive(1, 3'd0, 0, 3'd0, 0, 1, 3'd5, 2'b01, 0, 0); step();
        drive(1, 3'd5, 1, 3'd5, 1, 1, 3'd6, 2'b10, 0, 0); step();
        check("lu_stall", {15'd0, stall_seen}, 16'd1);
        check("lu_bubble", {12'd0, fw_a}, 16'd0);
        step();
        check("lu_stall_once", {15'd0, stall_seen}, 16'd0);
        check("lu_fwA", {12'd0, fw_a}, 16'b1101);
        check("lu_fwB", {12'd0, fw_b}, 16'b1101);
        check("lu_cnt", stall_count, 16'd1);

        // LD R5 with consumer frozen by memStall for 3 cycles
        drive(1, 3'd0, 0, 3'd0, 0, 1, 3'd5, 2'b01, 0, 0); step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 3'd5, 1, 3'd0, 0, 1, 3'd6, 2'b10, 1, 0); step();
            check("frz_stall", {15'd0, stall_seen}, 16'd0);
            check("frz_cnt", stall_count, 16'd1);
        end
        drive(1, 3'd5, 1, 3'd0, 0, 1, 3'd6, 2'b10, 0, 0); step();
        check("frz_then_stall", {15'd0, stall_seen}, 16'd1);
        step();
        check("frz_fwA", {12'd0, fw_a}, 16'b1101);
        check("frz_cnt2", stall_count, 16'd2);

        // Load-use coincident with flush
        drive(1, 3'd0, 0, 3'd0, 0, 1, 3'd5, 2'b01, 0, 0); step();
        drive(1, 3'd5, 1, 3'd0, 0, 1, 3'd6, 2'b10, 0, 1); step();
        check("fl_stall", {15'd0, stall_seen}, 16'd0);
        check("fl_fwA", {12'd0, fw_a}, 16'd0);
        check("fl_cnt", stall_count, 16'd2);

        // Reset in the middle of a stall, then forwarding resumes
        drive(1, 3'd0, 0, 3'd0, 0, 1, 3'd5, 2'b01, 0, 0); step();
        drive(1, 3'd5, 1, 3'd0, 0, 1, 3'd6, 2'b10, 0, 0);
        #2;
        check("pre_rst_stall", {15'd0, stall}, 16'd1);
        pulse_rst();
        drive(1, 3'd0, 0, 3'd0, 0, 1, 3'd1, 2'b10, 0, 0); step();
        drive(1, 3'd1, 1, 3'd0, 0, 1, 3'd2, 2'b10, 0, 0); step();
        check("post_rst_fwA", {12'd0, fw_a}, 16'b1010);

        // Randomized traffic over a small register window to force collisions
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 7) != 0),
                  3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 4) != 0), 3'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 63) == 0) pulse_rst();
            else step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
